cam_pixel_capture: RTL

CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

---
 rtl/cam_pixel_capture.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - camera byte-pair capture into a 17-bit FIFO with frame-start markers
// Optional 2x2 decimation of written pixels: define CAM_CAPTURE_DECIMATE_EN.
module cam_pixel_capture #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        calib_done,
    input  logic        cam_vsync,
    input  logic        href,
    input  logic [7:0]  p_data,
    input  logic        fifo_full,
    output logic [16:0] fifo_data,
    output logic        fifo_wr_en,
    output logic        frame_active,
    output logic        overflow,
    output logic        line_error,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        WAIT_CALIB,
        WAIT_BLANK,
        WAIT_FRAME,
        CAPTURE,
        DROP
    } state_t;

    localparam logic [10:0] WIDTH_L  = 11'(FRAME_WIDTH);
    localparam logic [9:0]  HEIGHT_L = 10'(FRAME_HEIGHT);

    state_t      state_q, state_d;
    logic        vsync_q, href_q, href_prev_q;
    logic [7:0]  data_q, hi_q, hi_d;
    logic        pair_q, pair_d;
    logic [10:0] pix_cnt_q, pix_cnt_d, pix_inc;
    logic [9:0]  line_cnt_q, line_cnt_d, line_inc;
    logic [16:0] fifo_data_q, fifo_data_d;
    logic        wr_en_q, wr_en_d;
    logic        overflow_q, overflow_d;
    logic        line_error_q, line_error_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        href_rise, href_fall, keep_pix;

    assign href_rise = href_q & ~href_prev_q;
    assign href_fall = ~href_q & href_prev_q;
    assign pix_inc   = (pix_cnt_q == 11'h7FF) ? pix_cnt_q : pix_cnt_q + 11'd1;
    assign line_inc  = (line_cnt_q == 10'h3FF) ? line_cnt_q : line_cnt_q + 10'd1;

`ifdef CAM_CAPTURE_DECIMATE_EN
    // Counters still run on the full stream; only the write is filtered.
    assign keep_pix = ~pix_cnt_q[0] & ~line_cnt_q[0];
`else
    assign keep_pix = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        pair_d        = pair_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        fifo_data_d   = fifo_data_q;
        wr_en_d       = 1'b0;
        overflow_d    = overflow_q;
        line_error_d  = line_error_q;
        frame_count_d = frame_count_q;

        if (!calib_done) begin
            state_d = WAIT_CALIB;
        end else begin
            case (state_q)
                WAIT_CALIB: state_d = WAIT_BLANK;
                WAIT_BLANK: if (vsync_q) state_d = WAIT_FRAME;
                WAIT_FRAME: begin
                    if (!vsync_q) begin
                        if (!fifo_full) begin
                            fifo_data_d = 17'h10000;
                            wr_en_d     = 1'b1;
                            line_cnt_d  = 10'd0;
                            pix_cnt_d   = 11'd0;
                            pair_d      = 1'b0;
                            state_d     = CAPTURE;
                        end else begin
                            overflow_d = 1'b1;
                            state_d    = DROP;
                        end
                    end
                end
                CAPTURE: begin
                    if (vsync_q) begin
                        if (line_cnt_q != HEIGHT_L) line_error_d = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        pair_d        = 1'b0;
                        state_d       = WAIT_FRAME;
                    end else if (href_q) begin
                        if (href_rise) pix_cnt_d = 11'd0;
                        // A rise always carries a first byte: pair_q was cleared at the last fall.
                        if (!pair_q) begin
                            hi_d   = data_q;
                            pair_d = 1'b1;
                        end else begin
                            pair_d    = 1'b0;
                            pix_cnt_d = pix_inc;
                            if (keep_pix) begin
                                if (fifo_full) begin
                                    overflow_d = 1'b1;
                                    state_d    = DROP;
                                end else begin
                                    fifo_data_d = {1'b0, hi_q, data_q};
                                    wr_en_d     = 1'b1;
                                end
                            end
                        end
                    end else if (href_fall) begin
                        pair_d     = 1'b0;
                        line_cnt_d = line_inc;
                        if (pix_cnt_q != WIDTH_L) line_error_d = 1'b1;
                    end
                end
                DROP:    state_d = WAIT_BLANK;
                default: state_d = WAIT_CALIB;
            endcase
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= WAIT_CALIB;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            href_prev_q   <= 1'b0;
            data_q        <= 8'd0;
            hi_q          <= 8'd0;
            pair_q        <= 1'b0;
            pix_cnt_q     <= 11'd0;
            line_cnt_q    <= 10'd0;
            fifo_data_q   <= 17'd0;
            wr_en_q       <= 1'b0;
            overflow_q    <= 1'b0;
            line_error_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= cam_vsync;
            href_q        <= href;
            href_prev_q   <= href_q;
            data_q        <= p_data;
            hi_q          <= hi_d;
            pair_q        <= pair_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            fifo_data_q   <= fifo_data_d;
            wr_en_q       <= wr_en_d;
            overflow_q    <= overflow_d;
            line_error_q  <= line_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fifo_data    = fifo_data_q;
    assign fifo_wr_en   = wr_en_q;
    assign frame_active = (state_q == CAPTURE);
    assign overflow     = overflow_q;
    assign line_error   = line_error_q;
    assign frame_count  = frame_count_q;

endmodule
